space_wire_pulse_sender: RTL

// - Source end of a clock-domain pulse crossing. Accepts single-cycle event pulses (e.g. TICK_IN, time-code strobes) in the
//   i_clk domain and delivers each one to a far domain as a level pulse under a four-phase req/ack handshake.
// - Far end detects the rising edge of o_async_pulse, re-times it into its own clock and returns i_async_ack.
// - Events arriving while a handshake is in flight are counted and sent back-to-back; none are merged until the counter saturates.

---
 rtl/space_wire_pulse_sender.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/space_wire_pulse_sender.sv
// space_wire_pulse_sender
//
// Source end of a clock-domain pulse crossing. Single-cycle events raised in
// the i_clk domain are queued in a small saturating counter. Each one is
// delivered to a far clock domain as a level pulse under a four-phase req/ack
// handshake. While a handshake is in flight, new events accumulate and are
// launched back-to-back. Events are dropped, with a strobe, only when the
// counter is full.
//
// Ports
//   i_clk          : sole clock; all state updates on its rising edge
//   i_reset        : synchronous, active-high reset
//   i_pulse        : one-cycle event request (i_clk domain)
//   i_async_ack    : acknowledge from the far domain (asynchronous)
//   o_async_pulse  : registered request level towards the far domain
//   o_busy         : high while a handshake is in progress
//   o_pending      : number of events queued but not yet launched
//   o_overflow     : one-cycle strobe, an event was dropped (queue full)
//   o_timeout      : one-cycle strobe, a handshake phase was abandoned

module space_wire_pulse_sender #(
  parameter int PENDING_WIDTH = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_HIGH      = 2,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_pulse,
  input  logic                     i_async_ack,
  output logic                     o_async_pulse,
  output logic                     o_busy,
  output logic [PENDING_WIDTH-1:0] o_pending,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  // The phase counter has to hold both the minimum-high length and the
  // timeout value, so it is sized for whichever of the two is larger.
  localparam int TO_BITS = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int MH_BITS = (MIN_HIGH > 0) ? $clog2(MIN_HIGH + 1) : 1;
  localparam int CNT_W   = (TO_BITS > MH_BITS) ? TO_BITS : MH_BITS;

  localparam logic [CNT_W-1:0]         CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]         MIN_HIGH_C = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0]         TIMEOUT_C  = CNT_W'(ACK_TIMEOUT);
  localparam bit                       TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX   = '1;
  localparam logic [PENDING_WIDTH-1:0] PEND_ONE   = PENDING_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   ackSync_q;
  logic [PENDING_WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]         phaseCnt_q, phaseCnt_d;
  logic                     pulse_q, busy_q, overflow_q, timeout_q;

  logic ackS;
  logic launch;
  logic timeoutHit;
  logic pendFull;
  logic pendInc;

  // Only the last synchronizer stage is seen by the control logic. The
  // earlier stages exist solely to resolve metastability.
  assign ackS = ackSync_q[SYNC_STAGES-1];

  assign pendFull = (pending_q == PEND_MAX);
  assign pendInc  = i_pulse & ~pendFull;

  // One counter serves both handshake phases (hcnt in ASSERT, rcnt in
  // RELEASE). It is loaded with 1 on every state entry, so its value
  // equals the number of cycles spent in the current state. It
  // saturates rather than wrapping.
  always_comb begin
    state_d    = state_q;
    phaseCnt_d = (phaseCnt_q == CNT_MAX) ? phaseCnt_q : phaseCnt_q + CNT_ONE;
    launch     = 1'b0;
    timeoutHit = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // An ack left high by the previous handshake blocks the next launch
        // until it has been seen low.
        if ((pending_q != '0) && !ackS) begin
          state_d    = ST_ASSERT;
          launch     = 1'b1;
          phaseCnt_d = CNT_ONE;
        end
      end
      ST_ASSERT: begin
        if (ackS && (phaseCnt_q >= MIN_HIGH_C)) begin
          state_d    = ST_RELEASE;
          phaseCnt_d = CNT_ONE;
        end else if (TIMEOUT_EN && !ackS && (phaseCnt_q == TIMEOUT_C)) begin
          state_d    = ST_RELEASE;
          phaseCnt_d = CNT_ONE;
          timeoutHit = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ackS) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN && (phaseCnt_q == TIMEOUT_C)) begin
          state_d    = ST_IDLE;
          timeoutHit = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A launch and an accepted event in the same cycle cancel out. At the
  // full level an incoming event is dropped, even when a launch frees a
  // slot in that same cycle.
  always_comb begin
    pending_d = pending_q;
    unique case ({pendInc, launch})
      2'b10:   pending_d = pending_q + PEND_ONE;
      2'b01:   pending_d = pending_q - PEND_ONE;
      default: pending_d = pending_q;
    endcase
  end

  // All outputs are registered. The request level and busy flag are derived
  // from the next state, so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      ackSync_q  <= '0;
      pending_q  <= '0;
      phaseCnt_q <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ackSync_q  <= {ackSync_q[SYNC_STAGES-2:0], i_async_ack};
      pending_q  <= pending_d;
      phaseCnt_q <= phaseCnt_d;
      pulse_q    <= (state_d == ST_ASSERT);
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= i_pulse & pendFull;
      timeout_q  <= timeoutHit;
    end
  end

  assign o_async_pulse = pulse_q;
  assign o_busy        = busy_q;
  assign o_pending     = pending_q;
  assign o_overflow    = overflow_q;
  assign o_timeout     = timeout_q;

endmodule
